// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and an
// instruction memory that can be filled through a valid/ready load port.
// While a load is in progress the fetch commands from the controller are
// ignored and Busy holds the controller in reset.
module instr_fetch_unit #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              PC_clr,
    input  logic              PC_up,
    input  logic              IR_ld,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] PC,
    input  logic              Load_start,
    input  logic              Load_valid,
    input  logic [DATA_W-1:0] Load_data,
    input  logic              Load_last,
    output logic              Load_ready,
    output logic              Load_done,
    output logic              Busy,
    output logic [ADDR_W:0]   Prog_len
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W:0]   prog_len_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] ir_reg;

    // No reset on the array so it maps onto memory resources; contents
    // survive reset and aborted loads.
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic xfer;
    logic full;

    // A word is accepted whenever we are loading and the source offers one.
    assign xfer = (state_reg == ST_LOAD) && Load_valid;
    // Last free slot: the transfer at this pointer ends the load.
    assign full = &wptr_reg;

    // Handshake/status outputs are straight decodes of the state register.
    assign Load_ready = (state_reg == ST_LOAD);
    assign Load_done  = (state_reg == ST_DONE);
    assign Busy       = (state_reg != ST_RUN);

    assign PC       = pc_reg;
    assign IR       = ir_reg;
    assign Prog_len = prog_len_reg;

    // Load sequencing: RUN -> LOAD on Load_start, LOAD -> DONE on the final
    // word, DONE lasts one cycle before fetching resumes.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_reg    <= ST_RUN;
            wptr_reg     <= '0;
            prog_len_reg <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (Load_start) begin
                        state_reg <= ST_LOAD;
                        wptr_reg  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        wptr_reg <= wptr_reg + ADDR_W'(1);
                        if (Load_last || full) begin
                            state_reg    <= ST_DONE;
                            prog_len_reg <= {1'b0, wptr_reg} + (ADDR_W+1)'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_RUN;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    // Memory write port; a reset edge must not commit the pending word.
    always_ff @(posedge Clk) begin
        if (ResetN && xfer) begin
            mem[wptr_reg] <= Load_data;
        end
    end

    // PC/IR: fetch commands only act in RUN; IR samples the pre-edge PC so
    // IR_ld together with PC_up fetches the current word and then advances.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            pc_reg <= '0;
            ir_reg <= '0;
        end else if (state_reg == ST_DONE) begin
            pc_reg <= '0;
            ir_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            if (IR_ld) begin
                ir_reg <= mem[pc_reg];
            end
            if (PC_clr) begin
                pc_reg <= '0;
            end else if (PC_up) begin
                pc_reg <= pc_reg + ADDR_W'(1);
            end
        end
    end

endmodule
